// File: rtl/pwm_bank_pkg.sv
// Shared constants, FSM state type and latency helper for the pwm_bank PWM block.
package pwm_bank_pkg;

  localparam logic [3:0] ADDR_TOP     = 4'hF;
  localparam int         DUTY_MAX     = 100;
  localparam int         CONV_MUL_CYC = 7;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT,
    NEXT_CH
  } state_t;

  // Clocks from an accepted duty write until the write port is free again.
  function automatic int CONV_LAT(int cnt_w);
    return cnt_w + 14;
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Register write port of pwm_bank: duty percent or TOP writes over valid/ready.
interface pwm_bank_if #(parameter int CNT_W = 16);

  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_addr;
  logic [CNT_W-1:0] wr_data;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);

endinterface

// File: rtl/pwm_duty_conv.sv
// Sequential converter cmp = floor(top*duty/100): shift-add multiply whose first
// step happens on the start edge, then a restoring divide by 100 in place.
module pwm_duty_conv
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] top,
  input  logic [6:0]       duty,
  output logic             done,
  output logic [CNT_W-1:0] cmp
);

  localparam int PW = CNT_W + 7;
  localparam int CW = $clog2(PW);

  logic          busy;
  logic          div_phase;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [5:0]    mplier;
  logic [6:0]    rem;
  logic [7:0]    trial;

  // done marks the cycle whose closing edge shifts in the last quotient bit.
  assign trial = {rem, acc[PW-1]};
  assign done  = busy && div_phase && (cnt == '0);
  assign cmp   = acc[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy      <= 1'b0;
      div_phase <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rem       <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      div_phase <= 1'b0;
      cnt       <= CW'(CONV_MUL_CYC - 2);
      acc       <= duty[0] ? PW'(top) : '0;
      mcand     <= PW'(top) << 1;
      mplier    <= duty[6:1];
      rem       <= '0;
    end else if (busy && !div_phase) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) begin
        div_phase <= 1'b1;
        cnt       <= CW'(PW - 1);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (busy) begin
      // The dividend shifts out of acc MSB-first while quotient bits enter at the LSB.
      if (trial >= 8'(DUTY_MAX)) begin
        rem <= 7'(trial - 8'(DUTY_MAX));
        acc <= {acc[PW-2:0], 1'b1};
      end else begin
        rem <= trial[6:0];
        acc <= {acc[PW-2:0], 1'b0};
      end
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// NUM_CH centered PWM outputs from one up/down counter with double-buffered TOP/compare.
// Optional PWM_READBACK_EN adds a registered rd_addr/rd_data readback port.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int TOP_DEF  = 100,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rstn,
  pwm_bank_if.slave         wr,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_start_o,
  output logic [CNT_W-1:0]  top_o
`ifdef PWM_READBACK_EN
  ,
  input  logic [3:0]        rd_addr,
  output logic [CNT_W-1:0]  rd_data
`endif
);

  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PSW-1:0]   presc;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             dir_down;
  logic             valley;
  logic [CNT_W-1:0] shadow_top, active_top;
  logic [CNT_W-1:0] shadow_cmp [NUM_CH];
  logic [CNT_W-1:0] active_cmp [NUM_CH];
  logic [6:0]       duty [NUM_CH];
  state_t           state, state_nx;
  logic [3:0]       cur_ch, sel;
  logic             reconv;
  logic             accept, is_ch, is_top, ready, commit;
  logic [6:0]       duty_clamp;
  logic [CNT_W-1:0] top_clamp;
  logic             conv_start, conv_done;
  logic [CNT_W-1:0] conv_top, conv_cmp;
  logic [6:0]       conv_duty;

  assign tick       = (presc == PSW'(TICK_DIV - 1));
  assign valley     = tick && dir_down && (cnt == '0);
  assign top_o      = active_top;
  assign accept     = (state == IDLE) && wr.wr_valid;
  assign is_ch      = (wr.wr_addr < 4'(NUM_CH));
  assign is_top     = (wr.wr_addr == ADDR_TOP);
  assign duty_clamp = (wr.wr_data > CNT_W'(DUTY_MAX)) ? 7'(DUTY_MAX) : wr.wr_data[6:0];
  assign top_clamp  = (wr.wr_data < CNT_W'(2)) ? CNT_W'(2) : wr.wr_data;
  assign wr.wr_ready = ready;

  // Endpoints 0 and TOP-1 are each held for one extra tick while direction flips.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc    <= '0;
      cnt      <= '0;
      dir_down <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (!dir_down) begin
          if (cnt == active_top - 1'b1) dir_down <= 1'b1;
          else                          cnt      <= cnt + 1'b1;
        end else begin
          if (cnt == '0) dir_down <= 1'b0;
          else           cnt      <= cnt - 1'b1;
        end
      end
    end
  end

  // Valley transfers are held off while a TOP reconversion is in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      active_top     <= CNT_W'(TOP_DEF);
      period_start_o <= 1'b0;
      pwm_o          <= '0;
      for (int i = 0; i < NUM_CH; i++) active_cmp[i] <= '0;
    end else begin
      period_start_o <= valley;
      if (valley && !reconv) begin
        active_top <= shadow_top;
        for (int i = 0; i < NUM_CH; i++) active_cmp[i] <= shadow_cmp[i];
      end
      for (int i = 0; i < NUM_CH; i++) pwm_o[i] <= (cnt < active_cmp[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && (is_ch || is_top)) state_nx = CONV;
      CONV:    if (conv_done)
                 state_nx = (reconv && (cur_ch != 4'(NUM_CH - 1))) ? NEXT_CH : COMMIT;
      COMMIT:  state_nx = IDLE;
      NEXT_CH: state_nx = CONV;
      default: state_nx = IDLE;
    endcase
  end

  // NEXT_CH both commits the finished channel and launches the next one.
  always_comb begin
    ready      = (state == IDLE);
    conv_start = (accept && (is_ch || is_top)) || (state == NEXT_CH);
    conv_top   = ((state == IDLE) && is_top) ? top_clamp : shadow_top;
    sel        = (state == NEXT_CH) ? cur_ch + 4'd1 : 4'd0;
    conv_duty  = '0;
    for (int i = 0; i < NUM_CH; i++) if (sel == 4'(i)) conv_duty = duty[i];
    if ((state == IDLE) && is_ch) conv_duty = duty_clamp;
    commit     = (state == COMMIT) || (state == NEXT_CH);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow_top <= CNT_W'(TOP_DEF);
      cur_ch     <= '0;
      reconv     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty[i]       <= '0;
        shadow_cmp[i] <= '0;
      end
    end else begin
      if (accept && is_ch) begin
        for (int i = 0; i < NUM_CH; i++) if (wr.wr_addr == 4'(i)) duty[i] <= duty_clamp;
        cur_ch <= wr.wr_addr;
        reconv <= 1'b0;
      end
      if (accept && is_top) begin
        shadow_top <= top_clamp;
        cur_ch     <= '0;
        reconv     <= 1'b1;
      end
      if (commit)
        for (int i = 0; i < NUM_CH; i++) if (cur_ch == 4'(i)) shadow_cmp[i] <= conv_cmp;
      if (state == NEXT_CH) cur_ch <= cur_ch + 4'd1;
      if (state == COMMIT)  reconv <= 1'b0;
    end
  end

  pwm_duty_conv #(.CNT_W(CNT_W)) u_conv (
    .clk   (clk),
    .rstn  (rstn),
    .start (conv_start),
    .top   (conv_top),
    .duty  (conv_duty),
    .done  (conv_done),
    .cmp   (conv_cmp)
  );

`ifdef PWM_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int i = 0; i < NUM_CH; i++) if (rd_addr == 4'(i)) rd_data <= CNT_W'(duty[i]);
      if (rd_addr == ADDR_TOP) rd_data <= active_top;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: vector table, valley/commit and reset corner
// cases, then random writes checked against an arithmetic period/duty model.
`timescale 1ns/1ps
module tb_pwm_bank;
  import pwm_bank_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 16;
  localparam int TOP_DEF  = 100;
  localparam int TICK_DIV = 1;
  localparam int LAT      = CONV_LAT(CNT_W);

  logic              clk;
  logic              rstn;
  logic [NUM_CH-1:0] pwm_o;
  logic              period_start_o;
  logic [CNT_W-1:0]  top_o;
`ifdef PWM_READBACK_EN
  logic [3:0]        rd_addr;
  logic [CNT_W-1:0]  rd_data;
`endif

  pwm_bank_if #(.CNT_W(CNT_W)) wr_if ();

  pwm_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TOP_DEF(TOP_DEF), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .wr             (wr_if),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .top_o          (top_o)
`ifdef PWM_READBACK_EN
    ,
    .rd_addr        (rd_addr),
    .rd_data        (rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    int         data;
    int         exp_busy;
    int         exp_ch;
    int         exp_high;
    int         exp_per;
    int         exp_top;
  } vec_t;

  vec_t vecs [9];
  int   total, passed;
  int   meas_per;
  int   meas_hi [NUM_CH];
  int   top_m;
  int   duty_m [NUM_CH];
  int   busy;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drives one write, then counts the cycles wr_ready stays low after the accept.
  task automatic apply_stimulus(input logic [3:0] addr, input int data, output int low);
    int guard = 0;
    while (!wr_if.wr_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = addr;
    wr_if.wr_data  = CNT_W'(data);
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    low = 0;
    while (!wr_if.wr_ready && low < 5000) begin
      low++;
      @(negedge clk);
    end
  endtask

  // One full period after a period_start pulse, up to and including the next pulse.
  task automatic measure();
    int guard = 0;
    meas_per = 0;
    for (int i = 0; i < NUM_CH; i++) meas_hi[i] = 0;
    while (!period_start_o && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check_output("period_start_seen", int'(period_start_o), 1);
    do begin
      @(negedge clk);
      meas_per++;
      for (int i = 0; i < NUM_CH; i++) if (pwm_o[i]) meas_hi[i]++;
    end while (!period_start_o && meas_per < 5000);
  endtask

  function automatic int model_high(int top, int d);
    return 2 * ((top * d) / 100);
  endfunction

  task automatic model_write(input logic [3:0] addr, input int data);
    if (addr < NUM_CH)      duty_m[addr] = (data > 100) ? 100 : data;
    else if (addr == 4'hF)  top_m        = (data < 2) ? 2 : data;
  endtask

  task automatic check_model(input string tag);
    check_output($sformatf("%s_period", tag), meas_per, 2 * top_m);
    for (int i = 0; i < NUM_CH; i++)
      check_output($sformatf("%s_high_ch%0d", tag, i), meas_hi[i], model_high(top_m, duty_m[i]));
  endtask

  initial begin
    total = 0;
    passed = 0;
    rstn = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
`ifdef PWM_READBACK_EN
    rd_addr = 4'd0;
`endif
    top_m = TOP_DEF;
    for (int i = 0; i < NUM_CH; i++) duty_m[i] = 0;

    vecs[0] = '{4'd0, 50,   LAT,          0, 100, 200,  100};
    vecs[1] = '{4'd1, 100,  LAT,          1, 200, 200,  100};
    vecs[2] = '{4'd2, 0,    LAT,          2, 0,   200,  100};
    vecs[3] = '{4'd3, 150,  LAT,          3, 200, 200,  100};
    vecs[4] = '{4'd1, 25,   LAT,          1, 50,  200,  100};
    vecs[5] = '{4'hF, 1000, NUM_CH * LAT, 1, 500, 2000, 1000};
    vecs[6] = '{4'hF, 1,    NUM_CH * LAT, 3, 4,   4,    2};
    vecs[7] = '{4'hF, 100,  NUM_CH * LAT, 0, 100, 200,  100};
    vecs[8] = '{4'd6, 77,   0,            0, 100, 200,  100};

    repeat (3) @(negedge clk);
    check_output("reset_pwm", int'(pwm_o), 0);
    check_output("reset_ready", int'(wr_if.wr_ready), 1);
    check_output("reset_top", int'(top_o), TOP_DEF);
    check_output("reset_period_start", int'(period_start_o), 0);
`ifdef PWM_READBACK_EN
    check_output("reset_rd_data", int'(rd_data), 0);
`endif
    rstn = 1'b1;
    measure();
    check_model("reset");

    for (int v = 0; v < 9; v++) begin
      apply_stimulus(vecs[v].addr, vecs[v].data, busy);
      model_write(vecs[v].addr, vecs[v].data);
      check_output($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
      @(negedge clk);
      measure();
      check_output($sformatf("vec%0d_period", v), meas_per, vecs[v].exp_per);
      check_output($sformatf("vec%0d_high", v), meas_hi[vecs[v].exp_ch], vecs[v].exp_high);
      check_output($sformatf("vec%0d_top", v), int'(top_o), vecs[v].exp_top);
      check_model($sformatf("vec%0d", v));
    end

`ifdef PWM_READBACK_EN
    rd_addr = 4'd3;
    @(negedge clk);
    check_output("readback_duty3", int'(rd_data), 100);
    rd_addr = 4'hF;
    @(negedge clk);
    check_output("readback_top", int'(rd_data), 100);
    rd_addr = 4'd7;
    @(negedge clk);
    check_output("readback_unused", int'(rd_data), 0);
`endif

    // Time the accept so the ch0=75 commit lands on the same edge as a valley.
    while (!period_start_o) @(negedge clk);
    repeat (169) @(negedge clk);
    apply_stimulus(4'd0, 75, busy);
    check_output("valley_commit_busy", busy, LAT);
    check_output("valley_commit_align", int'(period_start_o), 1);
    measure();
    check_output("valley_commit_old_high", meas_hi[0], 100);
    measure();
    check_output("valley_commit_new_high", meas_hi[0], 150);
    model_write(4'd0, 75);
    check_model("valley_commit");

    for (int r = 0; r < 6; r++) begin
      logic [3:0] addr;
      int         data;
      if ($urandom_range(3) == 0) begin
        addr = 4'hF;
        data = int'($urandom_range(130));
      end else begin
        addr = 4'($urandom_range(NUM_CH - 1));
        data = int'($urandom_range(200));
      end
      apply_stimulus(addr, data, busy);
      model_write(addr, data);
      check_output($sformatf("rand%0d_busy", r), busy, (addr == 4'hF) ? NUM_CH * LAT : LAT);
      @(negedge clk);
      measure();
      check_model($sformatf("rand%0d", r));
    end

    // Reset in the middle of a conversion must leave nothing committed.
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 4'd2;
    wr_if.wr_data  = CNT_W'(60);
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_output("midreset_ready", int'(wr_if.wr_ready), 1);
    check_output("midreset_pwm", int'(pwm_o), 0);
    check_output("midreset_top", int'(top_o), TOP_DEF);
    check_output("midreset_period_start", int'(period_start_o), 0);
    top_m = TOP_DEF;
    for (int i = 0; i < NUM_CH; i++) duty_m[i] = 0;
    measure();
    check_model("midreset");
`ifdef PWM_READBACK_EN
    rd_addr = 4'd2;
    @(negedge clk);
    check_output("midreset_rd_duty2", int'(rd_data), 0);
`endif

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised N-channel successor to the single centered PWM core.
- One shared up/down counter drives NUM_CH centered PWM outputs.
- Per-channel duty is written in percent over a valid/ready register port. The UART command parser is the intended driver of that port.
- Percent is converted to a compare value by a multi-cycle converter. Compare and period values are double-buffered and take effect only at the period boundary, so outputs never glitch.

Parameters:
- NUM_CH, 4, number of PWM channels (1..15).
- CNT_W, 16, counter, TOP and compare width.
- TOP_DEF, 100, reset half-period in ticks (2 ≤ TOP_DEF < 2^CNT_W).
- TICK_DIV, 1, clocks per counter tick (≥1). The prescaler width is sized internally.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write port idle / can accept
- wr_addr  in  4  0..NUM_CH-1 = channel duty; 4'hF = TOP; others ignored
- wr_data  in  CNT_W  duty percent (low 7 bits used) or TOP value
- pwm_o  out  NUM_CH  PWM outputs
- period_start_o  out  1  one-clock pulse at each period boundary
- top_o  out  CNT_W  active TOP value

Behaviour:
Reset (synchronous, rstn=0 at a clk edge):
- counter=0, direction up, prescaler=0.
- Active and shadow TOP = TOP_DEF; all duty, shadow and active compare values = 0.
- pwm_o=0, period_start_o=0, wr_ready=1, FSM=IDLE.
- Reset mid-conversion aborts the conversion; nothing is committed.

Counter:
- Advances once per TICK_DIV clocks.
- Up phase: 0,1..TOP-1. Down phase: TOP-1..0. Each endpoint value is held for two ticks, giving a period of 2*TOP ticks.
- The valley is the tick where down-phase 0 turns to up-phase 0. At that tick:
  - active TOP ← shadow TOP;
  - every active compare ← its shadow;
  - period_start_o pulses for exactly 1 clk.
- pwm_o[i] = (counter < active_cmp[i]), registered with 1 clk latency. High time = 2*cmp ticks, centered on the valley.
- cmp=0 gives a constant low output; cmp=TOP gives a constant high output.

Write handshake:
- A write is accepted on a clk edge with wr_valid && wr_ready.
- Accepted addresses NUM_CH..14 have no effect, and wr_ready stays 1.
- Duty write: value >100 is clamped to 100 and stored in duty[ch].
  - FSM goes IDLE→CONV; wr_ready drops to 0 the cycle after accept.
  - CONV computes cmp = floor(shadow_TOP*duty/100): 7-cycle shift-add multiply, then a (CNT_W+7)-cycle restoring divide.
  - COMMIT writes shadow_cmp[ch]; the FSM then returns to IDLE.
  - wr_ready returns to 1 exactly CNT_W+14 clks after accept.
- TOP write: value <2 is clamped to 2. It updates shadow TOP, then reconverts channels 0..NUM_CH-1 in order with the stored percents.
  - wr_ready stays low for NUM_CH*(CNT_W+14) clks.
- Shadow-to-active transfer at the valley always takes the latest committed shadows.
  - A channel committed after a TOP write but before a valley may pair with the new TOP only if both commits precede that valley.
  - Otherwise the transfer waits for the next valley; no partial-TOP period occurs because the reconversion sequence completes before any valley is used.
- Simultaneous commit and valley in the same clk: the valley transfer uses the pre-commit shadow, and the new value applies at the next valley.

Arithmetic:
- Product width is CNT_W+7; quotient is truncated to CNT_W.
- Because duty ≤ 100, cmp ≤ TOP always holds.

Optional Feature:
PWM_READBACK_EN:
- Defined: adds ports rd_addr (in, 4) and rd_data (out, CNT_W).
  - rd_data is registered with 1-clk latency.
  - It returns duty[ch] zero-extended for channel addresses, active TOP for 4'hF, and 0 otherwise.
  - Reset value of rd_data is 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package pwm_bank_pkg holds:
  - ADDR_TOP=4'hF, DUTY_MAX=100, CONV_MUL_CYC=7;
  - the FSM state typedef {IDLE, CONV, COMMIT, NEXT_CH};
  - a CONV_LAT(CNT_W) function returning CNT_W+14.
- One sub-module is natural: pwm_duty_conv, the sequential percent→compare multiplier/divider with a start/done handshake.
- Counter, prescaler, shadow registers and the FSM stay in pwm_bank.

Test Plan:
Bench settings: NUM_CH=4, CNT_W=16, TICK_DIV=1, TOP_DEF=100.
1. Release reset → pwm_o=4'b0000, wr_ready=1, top_o=100, period_start_o pulses every 200 clks.
2. Write ch0=50 → wr_ready low 30 clks; from the first valley after commit, pwm_o[0] is high 100 of 200 clks, centered on period_start_o.
3. Write ch1=100, ch2=0, ch3=150 → pwm_o[1] constant 1, pwm_o[2] constant 0, pwm_o[3] constant 1 (clamped); readback of duty[3]=100 when PWM_READBACK_EN is defined.
4. With ch1=25, write TOP=1000 → wr_ready low 120 clks; after the next valley, period is 2000 clks and pwm_o[1] is high 500 clks; write TOP=1 → top_o=2.
5. Commit ch0=75 on the same clk as the valley → current period keeps 50% with no glitch; 75% (150/200) starts at the following valley.
6. Assert rstn=0 for one clk mid-conversion → next edge: all outputs and registers are at reset values, wr_ready=1, and no compare is committed.
